// File: rtl/circ_331a_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : circ_331a_sweep_if
//  Description : Handshake/result bundle between the truth-table sweeper and
//                its environment. The master side issues start and returns F
//                from the circuit under check. The slave side (the sweeper)
//                drives the minterm and reports the results.
//  Revision    : 1.0  initial release
// ============================================================================
interface circ_331a_sweep_if;
    logic        start;
    logic        F;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_bad;

    modport master (
        output start, F,
        input  A, B, C, D, busy, done, pass, tt, mismatch_cnt, first_bad
    );

    modport slave (
        input  start, F,
        output A, B, C, D, busy, done, pass, tt, mismatch_cnt, first_bad
    );
endinterface
`default_nettype wire

// File: rtl/circ_331a_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : circ_331a_sweep
//  Description : Sequential truth-table sweeper. Drives all 16 minterms onto
//                A..D, samples F after SETTLE extra cycles per minterm,
//                builds the truth table and compares it with EXPECTED.
//  Revision    : 1.0  initial release
// ============================================================================
module circ_331a_sweep #(
    parameter logic [15:0] EXPECTED = 16'hF830,
    parameter int unsigned SETTLE   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    circ_331a_sweep_if.slave  sw_io
);

    localparam logic [3:0] c_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  mt_q, mt_d;       // current minterm; also drives A..D
    logic [3:0]  cnt_q, cnt_d;     // settle counter 0..SETTLE
    logic [15:0] tt_q, tt_d;
    logic [4:0]  mis_q, mis_d;
    logic [3:0]  fb_q, fb_d;
    logic        pass_q, pass_d;
    logic        w_bad;

    // State and datapath registers; reset clears every visible result at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            cnt_q   <= 4'd0;
            tt_q    <= 16'd0;
            mis_q   <= 5'd0;
            fb_q    <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            mis_q   <= mis_d;
            fb_q    <= fb_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state and datapath update for the sweep sequence
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        mis_d   = mis_q;
        fb_d    = fb_q;
        pass_d  = pass_q;
        w_bad   = (sw_io.F != EXPECTED[mt_q]);

        case (state_q)
            S_IDLE: begin
                if (sw_io.start) begin
                    state_d = S_DRIVE;
                    mt_d    = 4'd0;
                    cnt_d   = 4'd0;
                    tt_d    = 16'd0;
                    mis_d   = 5'd0;
                    fb_d    = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == c_SETTLE) begin
                    tt_d[mt_q] = sw_io.F;
                    if (w_bad) begin
                        mis_d = mis_q + 5'd1;
                        if (mis_q == 5'd0) begin
                            fb_d = mt_q;
                        end
                    end
                    cnt_d = 4'd0;
                    if (mt_q == 4'd15) begin
                        // Leave the minterm at 0 so A..D idle low in DONE
                        state_d = S_DONE;
                        mt_d    = 4'd0;
                        pass_d  = (tt_d == EXPECTED);
                    end else begin
                        mt_d = mt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sw_io.A            = mt_q[3];
    assign sw_io.B            = mt_q[2];
    assign sw_io.C            = mt_q[1];
    assign sw_io.D            = mt_q[0];
    assign sw_io.busy         = (state_q == S_DRIVE);
    assign sw_io.done         = (state_q == S_DONE);
    assign sw_io.pass         = pass_q;
    assign sw_io.tt           = tt_q;
    assign sw_io.mismatch_cnt = mis_q;
    assign sw_io.first_bad    = fb_q;

endmodule
`default_nettype wire

// File: tb/tb_circ_331a_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circ_331a_sweep
//  Description : Scoreboard bench for circ_331a_sweep. Two instances are used,
//                one with SETTLE=1 and one with SETTLE=3. Expected results are
//                derived from the truth table of the function fed back on F.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_circ_331a_sweep;

    localparam logic [15:0] c_EXP = 16'hF830;

    typedef struct {
        logic [15:0] tt;
        logic        pass;
        logic [4:0]  mis;
        logic [3:0]  fb;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic [15:0] fn1 = 16'h0000;
    logic [15:0] fn3 = 16'h0000;
    int   glitch3 = 0;        // 0 none, 1 force 1, 2 invert during settle
    int   e3 = 0;             // start edge of the current dut3 sweep
    int   cyc = 0;            // number of rising edges seen
    int   errors = 0;
    int   checks = 0;
    exp_t sb1[$];
    exp_t sb3[$];

    circ_331a_sweep_if bus1();
    circ_331a_sweep_if bus3();

    circ_331a_sweep #(.EXPECTED(c_EXP), .SETTLE(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .sw_io (bus1)
    );

    circ_331a_sweep #(.EXPECTED(c_EXP), .SETTLE(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .sw_io (bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Circuit under check for dut1: pure lookup of the chosen function
    logic [3:0] m1;
    assign m1 = {bus1.A, bus1.B, bus1.C, bus1.D};
    assign bus1.F = fn1[m1];
    assign bus1.start = start1;

    // Circuit under check for dut3: lookup, corrupted during the settle cycles
    logic [3:0] m3;
    logic       f3;
    assign m3 = {bus3.A, bus3.B, bus3.C, bus3.D};
    always_comb begin
        f3 = fn3[m3];
        if (glitch3 != 0 && bus3.busy && ((cyc - e3) % 4) < 3)
            f3 = (glitch3 == 1) ? 1'b1 : ~fn3[m3];
    end
    assign bus3.F = f3;
    assign bus3.start = start3;

    function automatic logic [15:0] golden();
        logic [15:0] g;
        logic [3:0]  v;
        g = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            g[i] = (v[3] & ((v[1] & v[0]) | v[2])) | (v[2] & ~v[1]);
        end
        return g;
    endfunction

    function automatic logic [15:0] f_is_a();
        logic [15:0] g;
        for (int i = 0; i < 16; i++) g[i] = (i >= 8);
        return g;
    endfunction

    // Reference: the captured table is simply the function's truth table
    function automatic exp_t model(input logic [15:0] fn);
        exp_t        e;
        logic [15:0] diff;
        diff    = fn ^ c_EXP;
        e.tt    = fn;
        e.pass  = (fn == c_EXP);
        e.mis   = 5'($countones(diff));
        e.fb    = 4'd0;
        for (int i = 15; i >= 0; i--) if (diff[i]) e.fb = 4'(i);
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 1) ? sb1.size() : sb3.size()) != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        if (((which == 1) ? sb1.size() : sb3.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d: done not seen within %0d cycles", which, budget);
            if (which == 1) sb1.delete(); else sb3.delete();
        end
    endtask

    task automatic sweep1(input logic [15:0] fn, input bit repulse);
        exp_t e;
        int   base;
        fn1 = fn;
        e = model(fn);
        base = cyc + 1;
        e.done_cyc = base + 32;
        sb1.push_back(e);
        start1 = 1'b1;
        next_cycle();
        start1 = 1'b0;
        if (repulse) begin
            while (cyc != base + 4) next_cycle();
            start1 = 1'b1;
            next_cycle();
            start1 = 1'b0;
            while (cyc != base + 19) next_cycle();
            start1 = 1'b1;
            next_cycle();
            start1 = 1'b0;
        end
        wait_sb(1, 60);
    endtask

    task automatic sweep3(input logic [15:0] fn, input int gmode);
        exp_t e;
        int   base;
        fn3 = fn;
        glitch3 = gmode;
        e = model(fn);
        base = cyc + 1;
        e3 = base;
        e.done_cyc = base + 64;
        sb3.push_back(e);
        start3 = 1'b1;
        next_cycle();
        start3 = 1'b0;
        wait_sb(3, 100);
    endtask

    task automatic check_done(input int which, input exp_t e);
        if (which == 1) begin
            chk("d1_tt", 32'(bus1.tt), 32'(e.tt));
            chk("d1_pass", 32'(bus1.pass), 32'(e.pass));
            chk("d1_mis", 32'(bus1.mismatch_cnt), 32'(e.mis));
            chk("d1_first_bad", 32'(bus1.first_bad), 32'(e.fb));
            chk("d1_done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("d1_busy_in_done", 32'(bus1.busy), 32'd0);
            chk("d1_abcd_in_done", 32'(m1), 32'd0);
        end else begin
            chk("d3_tt", 32'(bus3.tt), 32'(e.tt));
            chk("d3_pass", 32'(bus3.pass), 32'(e.pass));
            chk("d3_mis", 32'(bus3.mismatch_cnt), 32'(e.mis));
            chk("d3_first_bad", 32'(bus3.first_bad), 32'(e.fb));
            chk("d3_done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("d3_busy_in_done", 32'(bus3.busy), 32'd0);
        end
    endtask

    initial begin
        exp_t        e;
        int          base;
        logic [15:0] g;
        g = golden();

        // Monitors: pop one expectation per done pulse
        fork
            forever begin
                @(negedge clk);
                if (bus1.done) begin
                    if (sb1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL d1_unexpected_done: got done=1 expected no done");
                    end else begin
                        check_done(1, sb1.pop_front());
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (bus3.done) begin
                    if (sb3.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL d3_unexpected_done: got done=1 expected no done");
                    end else begin
                        check_done(3, sb3.pop_front());
                    end
                end
            end
        join_none

        // Reset values
        #2;
        chk("rst_abcd", 32'(m1), 32'd0);
        chk("rst_busy", 32'(bus1.busy), 32'd0);
        chk("rst_done", 32'(bus1.done), 32'd0);
        chk("rst_pass", 32'(bus1.pass), 32'd0);
        chk("rst_tt", 32'(bus1.tt), 32'd0);
        chk("rst_mis", 32'(bus1.mismatch_cnt), 32'd0);
        chk("rst_first_bad", 32'(bus1.first_bad), 32'd0);
        chk("rst3_busy", 32'(bus3.busy), 32'd0);
        repeat (2) next_cycle();
        rst = 1'b0;
        repeat (2) next_cycle();

        // Directed sweeps
        sweep1(g, 1'b0);
        repeat (3) next_cycle();
        chk("hold_tt", 32'(bus1.tt), 32'(c_EXP));
        chk("hold_pass", 32'(bus1.pass), 32'd1);
        sweep1(16'h0000, 1'b0);
        sweep1(f_is_a(), 1'b0);
        sweep1(g, 1'b1);
        sweep3(g, 1);

        // Reset in the middle of a sweep
        fn1 = 16'hFFFF;
        base = cyc + 1;
        start1 = 1'b1;
        next_cycle();
        start1 = 1'b0;
        while (cyc != base + 9) next_cycle();
        #2;
        chk("mid_tt", 32'(bus1.tt), 32'h000F);
        chk("mid_mis", 32'(bus1.mismatch_cnt), 32'd4);
        chk("mid_abcd", 32'(m1), 32'd4);
        chk("mid_busy", 32'(bus1.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_abcd", 32'(m1), 32'd0);
        chk("arst_busy", 32'(bus1.busy), 32'd0);
        chk("arst_tt", 32'(bus1.tt), 32'd0);
        chk("arst_mis", 32'(bus1.mismatch_cnt), 32'd0);
        repeat (2) next_cycle();
        rst = 1'b0;
        repeat (40) next_cycle();
        sweep1(g, 1'b0);

        // Randomized sweeps, back to back
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0) sweep1(g, 1'b0);
            else sweep1(16'($urandom), 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 0) sweep3(g, 2);
            else sweep3(16'($urandom), 2);
        end

        repeat (3) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
